rename_regfile: RTL and testbench

//  Multi-ported architectural register file with ROB-tag renaming (scoreboard) for the OoO core.

---
 rtl/rename_regfile.sv | 174 +++++++++++++++++
 tb/tb_rename_regfile.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rename_regfile.sv
// rename_regfile: multi-ported architectural register file with a RoB-tag rename scoreboard.
//
// Each register holds a committed value, a busy bit and the RoB tag of its youngest in-flight
// producer. The decoder queries NUM_RD operands per cycle and renames NUM_ISS destinations. The
// RoB retires NUM_CMT results per cycle. Committed values are always written, so a rollback
// (which only drops the busy/tag scoreboard) leaves a correct, fully ready architectural state.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   rdy        global enable; when low, nothing but rst changes state and forwarding is off
//   rollback   discard every outstanding rename at the next edge
//   rd_*       combinational query ports: index in, ready/value/tag out
//   iss_*      rename ports (port 0 oldest): destination index and RoB tag
//   cmt_*      commit ports (port 0 oldest): destination index, value and RoB tag
//   busy_cnt   registered number of busy registers
module rename_regfile #(
  parameter int unsigned REG_W   = 5,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ROB_W   = 4,
  parameter int unsigned NUM_RD  = 4,
  parameter int unsigned NUM_ISS = 2,
  parameter int unsigned NUM_CMT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      rollback,
  input  logic [NUM_RD*REG_W-1:0]   rd_idx,
  output logic [NUM_RD-1:0]         rd_rdy,
  output logic [NUM_RD*DATA_W-1:0]  rd_val,
  output logic [NUM_RD*ROB_W-1:0]   rd_tag,
  input  logic [NUM_ISS-1:0]        iss_en,
  input  logic [NUM_ISS*REG_W-1:0]  iss_idx,
  input  logic [NUM_ISS*ROB_W-1:0]  iss_tag,
  input  logic [NUM_CMT-1:0]        cmt_en,
  input  logic [NUM_CMT*REG_W-1:0]  cmt_idx,
  input  logic [NUM_CMT*DATA_W-1:0] cmt_val,
  input  logic [NUM_CMT*ROB_W-1:0]  cmt_tag,
  output logic [REG_W:0]            busy_cnt
);

  localparam int unsigned REG_CNT = 1 << REG_W;

  // Architectural state
  logic [DATA_W-1:0]  val_q [REG_CNT];
  logic [DATA_W-1:0]  val_d [REG_CNT];
  logic [ROB_W-1:0]   tag_q [REG_CNT];
  logic [ROB_W-1:0]   tag_d [REG_CNT];
  logic [REG_CNT-1:0] busy_q, busy_d;
  logic [REG_W:0]     busy_cnt_q, busy_cnt_d;

  // Unpacked views of the flat port buses
  logic [REG_W-1:0]  rd_idx_a  [NUM_RD];
  logic [REG_W-1:0]  iss_idx_a [NUM_ISS];
  logic [ROB_W-1:0]  iss_tag_a [NUM_ISS];
  logic [REG_W-1:0]  cmt_idx_a [NUM_CMT];
  logic [DATA_W-1:0] cmt_val_a [NUM_CMT];
  logic [ROB_W-1:0]  cmt_tag_a [NUM_CMT];

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_unpack
    assign rd_idx_a[k] = rd_idx[k*REG_W +: REG_W];
  end

  for (genvar j = 0; j < NUM_ISS; j++) begin : g_iss_unpack
    assign iss_idx_a[j] = iss_idx[j*REG_W +: REG_W];
    assign iss_tag_a[j] = iss_tag[j*ROB_W +: ROB_W];
  end

  for (genvar c = 0; c < NUM_CMT; c++) begin : g_cmt_unpack
    assign cmt_idx_a[c] = cmt_idx[c*REG_W +: REG_W];
    assign cmt_val_a[c] = cmt_val[c*DATA_W +: DATA_W];
    assign cmt_tag_a[c] = cmt_tag[c*ROB_W +: ROB_W];
  end

  // Per commit port: write the value (cmt_wr) and, when it retires the current producer,
  // release the scoreboard entry (cmt_clr). Both are already gated by the global enable.
  logic [NUM_CMT-1:0] cmt_wr;
  logic [NUM_CMT-1:0] cmt_clr;

  always_comb begin
    cmt_wr  = '0;
    cmt_clr = '0;
    for (int c = 0; c < NUM_CMT; c++) begin
      cmt_wr[c]  = rdy && cmt_en[c] && (cmt_idx_a[c] != '0);
      cmt_clr[c] = cmt_wr[c] && busy_q[cmt_idx_a[c]] && (tag_q[cmt_idx_a[c]] == cmt_tag_a[c]);
    end
  end

  // Next-state. Later assignments override earlier ones, which encodes the priorities:
  // higher port over lower port, and rollback > issue > commit for busy/tag.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;

    for (int c = 0; c < NUM_CMT; c++) begin
      if (cmt_wr[c]) begin
        val_d[cmt_idx_a[c]] = cmt_val_a[c];
      end
    end

    // Compared against the pre-update tag, so any matching port releases the entry.
    for (int c = 0; c < NUM_CMT; c++) begin
      if (cmt_clr[c]) begin
        busy_d[cmt_idx_a[c]] = 1'b0;
        tag_d[cmt_idx_a[c]]  = '0;
      end
    end

    if (rdy) begin
      if (rollback) begin
        busy_d = '0;
        for (int i = 0; i < REG_CNT; i++) begin
          tag_d[i] = '0;
        end
      end else begin
        for (int j = 0; j < NUM_ISS; j++) begin
          if (iss_en[j] && (iss_idx_a[j] != '0)) begin
            busy_d[iss_idx_a[j]] = 1'b1;
            tag_d[iss_idx_a[j]]  = iss_tag_a[j];
          end
        end
      end
    end
  end

  always_comb begin
    busy_cnt_d = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      busy_cnt_d = busy_cnt_d + {{REG_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      for (int i = 0; i < REG_CNT; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      for (int i = 0; i < REG_CNT; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign busy_cnt = busy_cnt_q;

  // Read ports. A commit that retires the current producer this cycle is forwarded
  // (highest matching port wins). Same-cycle renames are deliberately not visible here.
  always_comb begin
    rd_rdy = '0;
    rd_val = '0;
    rd_tag = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_rdy[k]                  = !busy_q[rd_idx_a[k]];
      rd_val[k*DATA_W +: DATA_W] = val_q[rd_idx_a[k]];
      rd_tag[k*ROB_W +: ROB_W]   = busy_q[rd_idx_a[k]] ? tag_q[rd_idx_a[k]] : '0;
      for (int c = 0; c < NUM_CMT; c++) begin
        if (cmt_clr[c] && (cmt_idx_a[c] == rd_idx_a[k])) begin
          rd_rdy[k]                  = 1'b1;
          rd_val[k*DATA_W +: DATA_W] = cmt_val_a[c];
          rd_tag[k*ROB_W +: ROB_W]   = '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rename_regfile.sv
module tb_rename_regfile;

  localparam int REG_W   = 5;
  localparam int DATA_W  = 32;
  localparam int ROB_W   = 4;
  localparam int NUM_RD  = 4;
  localparam int NUM_ISS = 2;
  localparam int NUM_CMT = 2;

  logic                      clk = 1'b0;
  logic                      rst, rdy, rollback;
  logic [NUM_RD*REG_W-1:0]   rd_idx;
  logic [NUM_RD-1:0]         rd_rdy;
  logic [NUM_RD*DATA_W-1:0]  rd_val;
  logic [NUM_RD*ROB_W-1:0]   rd_tag;
  logic [NUM_ISS-1:0]        iss_en;
  logic [NUM_ISS*REG_W-1:0]  iss_idx;
  logic [NUM_ISS*ROB_W-1:0]  iss_tag;
  logic [NUM_CMT-1:0]        cmt_en;
  logic [NUM_CMT*REG_W-1:0]  cmt_idx;
  logic [NUM_CMT*DATA_W-1:0] cmt_val;
  logic [NUM_CMT*ROB_W-1:0]  cmt_tag;
  logic [REG_W:0]            busy_cnt;

  rename_regfile #(
    .REG_W(REG_W), .DATA_W(DATA_W), .ROB_W(ROB_W),
    .NUM_RD(NUM_RD), .NUM_ISS(NUM_ISS), .NUM_CMT(NUM_CMT)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .rd_idx(rd_idx), .rd_rdy(rd_rdy), .rd_val(rd_val), .rd_tag(rd_tag),
    .iss_en(iss_en), .iss_idx(iss_idx), .iss_tag(iss_tag),
    .cmt_en(cmt_en), .cmt_idx(cmt_idx), .cmt_val(cmt_val), .cmt_tag(cmt_tag),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        rdy, rb;
    bit [1:0]  ien;
    int        ii0, it0, ii1, it1;
    bit [1:0]  cen;
    int        ci0, cv0, ct0, ci1, cv1, ct1;
    int        r0, r1;
    bit        e0r; int e0v, e0t;
    bit        e1r; int e1v, e1t;
    int        ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic add(input bit rdy_i, input bit rb, input bit [1:0] ien,
                     input int ii0, input int it0, input int ii1, input int it1,
                     input bit [1:0] cen, input int ci0, input int cv0, input int ct0,
                     input int ci1, input int cv1, input int ct1,
                     input int r0, input int r1,
                     input bit e0r, input int e0v, input int e0t,
                     input bit e1r, input int e1v, input int e1t, input int ecnt);
    vec_t v;
    v.rdy = rdy_i; v.rb = rb; v.ien = ien;
    v.ii0 = ii0; v.it0 = it0; v.ii1 = ii1; v.it1 = it1;
    v.cen = cen; v.ci0 = ci0; v.cv0 = cv0; v.ct0 = ct0;
    v.ci1 = ci1; v.cv1 = cv1; v.ct1 = ct1;
    v.r0 = r0; v.r1 = r1;
    v.e0r = e0r; v.e0v = e0v; v.e0t = e0t;
    v.e1r = e1r; v.e1v = e1v; v.e1t = e1t;
    v.ecnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    rd_idx = '0; iss_en = '0; iss_idx = '0; iss_tag = '0;
    cmt_en = '0; cmt_idx = '0; cmt_val = '0; cmt_tag = '0;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Read port k packed as {rdy, val, tag}
  function automatic logic [63:0] port(input int k);
    return {27'd0, rd_rdy[k], rd_val[k*DATA_W +: DATA_W], rd_tag[k*ROB_W +: ROB_W]};
  endfunction

  function automatic logic [63:0] expp(input bit r, input int v, input int t);
    return {27'd0, r, DATA_W'(v), ROB_W'(t)};
  endfunction

  task automatic set_rd(input int r0, input int r1, input int r2, input int r3);
    rd_idx = {REG_W'(r3), REG_W'(r2), REG_W'(r1), REG_W'(r0)};
  endtask

  initial begin
    idle();
    // rdy rb ien ii0 it0 ii1 it1 cen ci0 cv0 ct0 ci1 cv1 ct1 r0 r1 | e0 | e1 | cnt
    add(1,0,2'b01, 0,3, 0,0, 2'b00, 0,0,0, 0,0,0,  0,5,  1,0,0,      1,0,0,      0); // x0 rename
    add(1,0,2'b01, 5,2, 0,0, 2'b00, 0,0,0, 0,0,0,  5,0,  1,0,0,      1,0,0,      0);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  5,0,  0,0,2,      1,0,0,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b01, 5,'hAB,2, 0,0,0, 5,0, 1,'hAB,0,  1,0,0,      1); // fwd
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  5,0,  1,'hAB,0,   1,0,0,      0);
    add(1,0,2'b01, 7,1, 0,0, 2'b00, 0,0,0, 0,0,0,  7,0,  1,0,0,      1,0,0,      0);
    add(1,0,2'b01, 7,4, 0,0, 2'b00, 0,0,0, 0,0,0,  7,0,  0,0,1,      1,0,0,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b01, 7,'h11,1, 0,0,0, 7,0, 0,0,4,     1,0,0,      1); // stale
    add(1,1,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  7,5,  0,'h11,4,   1,'hAB,0,   1);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  7,5,  1,'h11,0,   1,'hAB,0,   0);
    add(1,0,2'b11, 9,6, 9,7, 2'b00, 0,0,0, 0,0,0,  9,0,  1,0,0,      1,0,0,      0);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  9,0,  0,0,7,      1,0,0,      1);
    add(1,0,2'b01, 9,2, 0,0, 2'b01, 9,'h99,7, 0,0,0, 9,0, 1,'h99,0,  1,0,0,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  9,0,  0,'h99,2,   1,0,0,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b11, 3,1,0, 3,2,5,  3,0,  1,0,0,      1,0,0,      1);
    add(1,1,2'b01, 4,3, 0,0, 2'b00, 0,0,0, 0,0,0,  3,4,  1,2,0,      1,0,0,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  4,9,  1,0,0,      1,'h99,0,   0);
    add(1,0,2'b01, 6,5, 0,0, 2'b00, 0,0,0, 0,0,0,  6,0,  1,0,0,      1,0,0,      0);
    add(0,1,2'b01,10,1, 0,0, 2'b01, 6,'h66,5, 0,0,0, 6,10, 0,0,5,    1,0,0,      1); // rdy=0
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  6,10, 0,0,5,      1,0,0,      1);
    add(1,0,2'b01,12,8, 0,0, 2'b00, 0,0,0, 0,0,0, 12,0,  1,0,0,      1,0,0,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b11,12,'hC0,8,12,'hC1,3, 12,6, 1,'hC0,0, 0,0,5,   2);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0, 12,6,  1,'hC1,0,   0,0,5,      1);
    add(1,0,2'b00, 0,0, 0,0, 2'b11, 0,'hFF,0, 6,'h66,5, 6,0, 1,'h66,0, 1,0,0,    1);
    add(1,0,2'b00, 0,0, 0,0, 2'b00, 0,0,0, 0,0,0,  6,0,  1,'h66,0,   1,0,0,      0);

    // Reset, then sweep every register on all four ports
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int r = 0; r < 32; r += 4) begin
      set_rd(r, r + 1, r + 2, r + 3);
      @(negedge clk);
      for (int k = 0; k < NUM_RD; k++) check($sformatf("reset_x%0d", r + k), port(k), expp(1, 0, 0));
      check("reset_cnt", 64'(busy_cnt), 64'd0);
      @(posedge clk);
      #1;
    end

    // Table-driven vectors: inputs applied after posedge, outputs sampled at negedge
    foreach (vecs[i]) begin
      idle();
      rdy      = vecs[i].rdy;
      rollback = vecs[i].rb;
      iss_en   = vecs[i].ien;
      iss_idx  = {REG_W'(vecs[i].ii1), REG_W'(vecs[i].ii0)};
      iss_tag  = {ROB_W'(vecs[i].it1), ROB_W'(vecs[i].it0)};
      cmt_en   = vecs[i].cen;
      cmt_idx  = {REG_W'(vecs[i].ci1), REG_W'(vecs[i].ci0)};
      cmt_val  = {DATA_W'(vecs[i].cv1), DATA_W'(vecs[i].cv0)};
      cmt_tag  = {ROB_W'(vecs[i].ct1), ROB_W'(vecs[i].ct0)};
      set_rd(vecs[i].r0, vecs[i].r1, 0, 0);
      @(negedge clk);
      check($sformatf("v%0d_rd0", i), port(0), expp(vecs[i].e0r, vecs[i].e0v, vecs[i].e0t));
      check($sformatf("v%0d_rd1", i), port(1), expp(vecs[i].e1r, vecs[i].e1v, vecs[i].e1t));
      check($sformatf("v%0d_cnt", i), 64'(busy_cnt), 64'(vecs[i].ecnt));
      @(posedge clk);
      #1;
    end

    // Four ports reading four distinct committed registers
    idle();
    set_rd(5, 7, 3, 12);
    @(negedge clk);
    check("multi_rd0", port(0), expp(1, 'hAB, 0));
    check("multi_rd1", port(1), expp(1, 'h11, 0));
    check("multi_rd2", port(2), expp(1, 2, 0));
    check("multi_rd3", port(3), expp(1, 'hC1, 0));

    // Rename x8, then reset while rdy is low: reset must still clear everything
    iss_en = 2'b01; iss_idx = REG_W'(8); iss_tag = ROB_W'(1);
    @(posedge clk);
    #1 idle();
    set_rd(8, 5, 0, 0);
    @(negedge clk);
    check("pre_rst_x8", port(0), expp(0, 0, 1));
    check("pre_rst_cnt", 64'(busy_cnt), 64'd1);
    rst = 1'b1; rdy = 1'b0;
    @(posedge clk);
    #1 idle();
    set_rd(8, 5, 0, 0);
    @(negedge clk);
    check("post_rst_x8", port(0), expp(1, 0, 0));
    check("post_rst_x5", port(1), expp(1, 0, 0));
    check("post_rst_cnt", 64'(busy_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
